// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types for the sequential multiply/divide unit.
//   state_e       - controller states
//   booth_digit_e - radix-4 Booth digit selected from a 3-bit multiplier window
//   cnt_width()   - iteration counter width for a given operand width
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_digit_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_enc.sv
// booth_enc: radix-4 Booth recoder (combinational).
//   win   in  3  multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   digit out    partial-product select: 0, +1, +2, -1, -2 times multiplicand
module booth_enc
  import multdiv_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_e digit
);

  always_comb begin
    digit = BD_ZERO;
    case (win)
      3'b001, 3'b010: digit = BD_POS1;
      3'b011:         digit = BD_POS2;
      3'b100:         digit = BD_NEG2;
      3'b101, 3'b110: digit = BD_NEG1;
      default:        digit = BD_ZERO;
    endcase
  end

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential signed multiply (radix-4 Booth, WIDTH/2 cycles) and
// divide (non-restoring on magnitudes, WIDTH cycles + sign fix-up).
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   data_operandA/B     multiplicand/dividend, multiplier/divisor (signed)
//   ctrl_MULT/ctrl_DIV  start pulses (operands latched on that edge; MULT wins)
//   data_result         product low half or quotient, held until next start
//   data_exception      overflow / divide-by-zero, held with data_result
//   data_resultRDY      one-cycle completion pulse
//   data_result_hi      product high half or signed remainder
//                       (present only when MULTDIV_HI_EN is defined)
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef MULTDIV_HI_EN
  ,
  output logic [WIDTH-1:0] data_result_hi
`endif
);

  localparam int unsigned      CW       = cnt_width(WIDTH);
  localparam int unsigned      AW       = WIDTH + 2;
  localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0]    DIV_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1) {1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: Booth upper accumulator / signed partial remainder
  // qr : multiplier shift register / dividend-then-quotient shift register
  // mc : multiplicand / divisor magnitude
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic             qm1_q, qm1_d;
  logic             is_div_q, is_div_d;
  logic             qneg_q, qneg_d;
  logic             dz_q, dz_d;
  logic             dovf_q, dovf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
`ifdef MULTDIV_HI_EN
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] rem_fix;
`endif

  booth_digit_e     digit;
  logic [AW-1:0]    mc_ext, d_ext, pp, mul_sum, div_shift, div_next;
  logic [WIDTH-1:0] mag_a, mag_b, quo;
  logic [WIDTH:0]   prod_top;
  logic             mul_ovf;

  booth_enc u_booth (
    .win  ({qr_q[1:0], qm1_q}),
    .digit(digit)
  );

  always_comb begin
    mc_ext = {{2{mc_q[WIDTH-1]}}, mc_q};
    d_ext  = {2'b00, mc_q};
    pp     = '0;
    case (digit)
      BD_POS1: pp = mc_ext;
      BD_POS2: pp = mc_ext << 1;
      BD_NEG1: pp = -mc_ext;
      BD_NEG2: pp = -(mc_ext << 1);
      default: pp = '0;
    endcase
    mul_sum   = acc_q + pp;
    // Non-restoring step: the sign of the old remainder picks add or subtract.
    div_shift = {acc_q[AW-2:0], qr_q[WIDTH-1]};
    div_next  = acc_q[AW-1] ? (div_shift + d_ext) : (div_shift - d_ext);
    mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    quo       = qneg_q ? -qr_q : qr_q;
    // Product fits in WIDTH bits iff bits [2W-1:W-1] are all equal.
    prod_top  = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    mul_ovf   = ~((&prod_top) | ~(|prod_top));
`ifdef MULTDIV_HI_EN
    rem_fix   = acc_q[AW-1] ? (acc_q[WIDTH-1:0] + mc_q) : acc_q[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    mc_d     = mc_q;
    qm1_d    = qm1_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    dz_d     = dz_q;
    dovf_d   = dovf_q;
    res_d    = res_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef MULTDIV_HI_EN
    hi_d     = hi_q;
    rneg_d   = rneg_q;
`endif
    // A start in any state abandons the current operation.
    if (ctrl_MULT || ctrl_DIV) begin
      cnt_d    = '0;
      acc_d    = '0;
      qm1_d    = 1'b0;
      res_d    = '0;
      exc_d    = 1'b0;
      is_div_d = !ctrl_MULT;
`ifdef MULTDIV_HI_EN
      hi_d     = '0;
      rneg_d   = !ctrl_MULT && data_operandA[WIDTH-1];
`endif
      if (ctrl_MULT) begin
        state_d = MULT;
        qr_d    = data_operandB;
        mc_d    = data_operandA;
        qneg_d  = 1'b0;
        dz_d    = 1'b0;
        dovf_d  = 1'b0;
      end else begin
        state_d = DIV;
        qr_d    = mag_a;
        mc_d    = mag_b;
        qneg_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_d    = (data_operandB == '0);
        dovf_d  = (data_operandA == MOST_NEG) && (data_operandB == '1);
      end
    end else begin
      case (state_q)
        MULT: begin
          acc_d = {{2{mul_sum[AW-1]}}, mul_sum[AW-1:2]};
          qr_d  = {mul_sum[1:0], qr_q[WIDTH-1:2]};
          qm1_d = qr_q[1];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == MUL_LAST) state_d = DONE;
        end
        DIV: begin
          acc_d = div_next;
          qr_d  = {qr_q[WIDTH-2:0], ~div_next[AW-1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == DIV_LAST) state_d = DONE;
        end
        DONE: begin
          rdy_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
          qr_d    = '0;
          qm1_d   = 1'b0;
          if (is_div_q) begin
            res_d = dz_q ? '0 : quo;
            exc_d = dz_q | dovf_q;
`ifdef MULTDIV_HI_EN
            hi_d  = dz_q ? '0 : (rneg_q ? -rem_fix : rem_fix);
`endif
          end else begin
            res_d = qr_q;
            exc_d = mul_ovf;
`ifdef MULTDIV_HI_EN
            hi_d  = acc_q[WIDTH-1:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      mc_q     <= '0;
      qm1_q    <= 1'b0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      dovf_q   <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef MULTDIV_HI_EN
      hi_q     <= '0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      mc_q     <= mc_d;
      qm1_q    <= qm1_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      dz_q     <= dz_d;
      dovf_q   <= dovf_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef MULTDIV_HI_EN
      hi_q     <= hi_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
`ifdef MULTDIV_HI_EN
  assign data_result_hi = hi_q;
`endif

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: self-checking bench for multdiv_seq at WIDTH=32 and WIDTH=8.
// Honours MULTDIV_HI_EN when defined (checks data_result_hi as well).
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        c_mult = 1'b0, c_div = 1'b0;
  logic [31:0] res;
  logic        exc, rdy;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        m8 = 1'b0, d8 = 1'b0;
  logic [7:0]  res8;
  logic        exc8, rdy8;
`ifdef MULTDIV_HI_EN
  logic [31:0] hi;
  logic [7:0]  hi8;
`endif

  int nerr = 0;
  int nchk = 0;

  always #5 clock = ~clock;

  multdiv_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(op_a), .data_operandB(op_b),
    .ctrl_MULT(c_mult), .ctrl_DIV(c_div),
    .data_result(res), .data_exception(exc), .data_resultRDY(rdy)
`ifdef MULTDIV_HI_EN
    , .data_result_hi(hi)
`endif
  );

  multdiv_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset),
    .data_operandA(a8), .data_operandB(b8),
    .ctrl_MULT(m8), .ctrl_DIV(d8),
    .data_result(res8), .data_exception(exc8), .data_resultRDY(rdy8)
`ifdef MULTDIV_HI_EN
    , .data_result_hi(hi8)
`endif
  );

  // ---------------- reference model (plain signed arithmetic) ----------------
  function automatic longint sx(input logic [31:0] v, input int w);
    longint t;
    t = longint'(v) & ((longint'(1) << w) - 1);
    if (t[w-1]) t = t - (longint'(1) << w);
    return t;
  endfunction

  task automatic model(input int w, input bit is_mul, input logic [31:0] a, b,
                       output logic [31:0] e_res, e_hi, output logic e_exc);
    longint sa, sb, lo_lim, hi_lim, r, h, msk;
    sa = sx(a, w);
    sb = sx(b, w);
    lo_lim = -(longint'(1) << (w - 1));
    hi_lim = (longint'(1) << (w - 1)) - 1;
    msk = (longint'(1) << w) - 1;
    if (is_mul) begin
      r = sa * sb;
      h = r >>> w;
      e_exc = (r < lo_lim) || (r > hi_lim);
    end else if (sb == 0) begin
      r = 0; h = 0; e_exc = 1'b1;
    end else begin
      r = sa / sb;
      h = sa % sb;
      e_exc = (r > hi_lim);
    end
    e_res = 32'(r & msk);
    e_hi  = 32'(h & msk);
  endtask

  // ---------------- drive / sample helpers ----------------
  task automatic drive(input int w, input bit m, input bit d, input logic [31:0] a, b);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; m8 = m; d8 = d;
    end else begin
      op_a = a; op_b = b; c_mult = m; c_div = d;
    end
  endtask

  task automatic sample(input int w, output logic [31:0] r, h, output logic e, y);
    if (w == 8) begin
      r = {24'b0, res8}; e = exc8; y = rdy8;
`ifdef MULTDIV_HI_EN
      h = {24'b0, hi8};
`else
      h = '0;
`endif
    end else begin
      r = res; e = exc; y = rdy;
`ifdef MULTDIV_HI_EN
      h = hi;
`else
      h = '0;
`endif
    end
  endtask

  // Issues one operation and records completion latency (edges after the start
  // edge), pulse count, start-edge clearing and post-RDY hold behaviour.
  task automatic run_op(input int w, input bit m, input bit d, input logic [31:0] a, b,
                        output int lat, output int pulses, output bit clr_ok, output bit hold_ok,
                        output logic [31:0] r_res, r_hi, output logic r_exc);
    int lim;
    logic [31:0] cr, ch;
    logic ce, cy;
    lim = (m ? w / 2 : w) + 4;
    r_res = 'x; r_hi = 'x; r_exc = 1'bx;
    @(negedge clock);
    drive(w, m, d, a, b);
    @(negedge clock);
    drive(w, 1'b0, 1'b0, $urandom, $urandom);
    sample(w, cr, ch, ce, cy);
    clr_ok = (cr == 0) && (ch == 0) && (ce == 0) && (cy == 0);
    lat = -1;
    pulses = 0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clock);
      sample(w, cr, ch, ce, cy);
      if (cy) begin
        pulses++;
        if (lat < 0) begin
          lat = k; r_res = cr; r_hi = ch; r_exc = ce;
        end
      end
    end
    hold_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      sample(w, cr, ch, ce, cy);
      if (cy || cr !== r_res || ce !== r_exc || ch !== r_hi) hold_ok = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    nchk++;
    if ({res, exc, rdy} !== 34'b0 || {res8, exc8, rdy8} !== 10'b0) begin
      nerr++;
      $display("FAIL reset_async got=%h/%h exp=0", {res, exc, rdy}, {res8, exc8, rdy8});
    end
    repeat (3) @(negedge clock);
    nchk++;
    if ({res, exc, rdy} !== 34'b0 || {res8, exc8, rdy8} !== 10'b0) begin
      nerr++;
      $display("FAIL reset_held got=%h/%h exp=0", {res, exc, rdy}, {res8, exc8, rdy8});
    end
    reset = 1'b0;
  endtask

  typedef struct {
    bit m; bit d;
    logic [31:0] a, b, res, hi;
    logic exc;
  } vec_t;

  task automatic test_directed;
    vec_t tab[10];
    int lat, pulses, elat;
    bit clr_ok, hold_ok;
    logic [31:0] r_res, r_hi;
    logic r_exc;
    tab[0] = '{1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 1'b1};
    tab[1] = '{1, 0, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0};
    tab[2] = '{0, 1, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    tab[3] = '{0, 1, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
    tab[4] = '{0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
    tab[5] = '{1, 0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1};
    tab[6] = '{0, 1, 32'h00000007, 32'hFFFFFF9C, 32'h00000000, 32'h00000007, 1'b0};
    tab[7] = '{0, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tab[8] = '{1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
    tab[9] = '{1, 1, 32'h00000006, 32'h00000007, 32'h0000002A, 32'h00000000, 1'b0};
    for (int i = 0; i < 10; i++) begin
      run_op(32, tab[i].m, tab[i].d, tab[i].a, tab[i].b, lat, pulses, clr_ok, hold_ok, r_res, r_hi, r_exc);
      elat = tab[i].m ? 17 : 33;
      nchk++;
      if (lat !== elat || pulses !== 1) begin
        nerr++;
        $display("FAIL dir%0d_latency got=%0d pulses=%0d exp=%0d pulses=1", i, lat, pulses, elat);
      end
      nchk++;
      if (!clr_ok || !hold_ok) begin
        nerr++;
        $display("FAIL dir%0d_clear_hold got clr=%0d hold=%0d exp 1/1", i, clr_ok, hold_ok);
      end
      nchk++;
      if (r_res !== tab[i].res || r_exc !== tab[i].exc) begin
        nerr++;
        $display("FAIL dir%0d_result got=%h exc=%b exp=%h exc=%b", i, r_res, r_exc, tab[i].res, tab[i].exc);
      end
`ifdef MULTDIV_HI_EN
      nchk++;
      if (r_hi !== tab[i].hi) begin
        nerr++;
        $display("FAIL dir%0d_hi got=%h exp=%h", i, r_hi, tab[i].hi);
      end
`endif
    end
  endtask

  task automatic test_random(input int w, input int n);
    int lat, pulses, elat;
    bit clr_ok, hold_ok, m;
    logic [31:0] a, b, r_res, r_hi, e_res, e_hi;
    logic r_exc, e_exc;
    for (int i = 0; i < n; i++) begin
      m = $urandom_range(0, 1);
      a = $urandom;
      b = (i % 4 == 0 || w == 8) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      if (i % 5 == 1) a = 32'($urandom_range(0, 200)) - 32'd100;
      model(w, m, a, b, e_res, e_hi, e_exc);
      run_op(w, m, !m, a, b, lat, pulses, clr_ok, hold_ok, r_res, r_hi, r_exc);
      elat = (m ? w / 2 : w) + 1;
      nchk++;
      if (lat !== elat || pulses !== 1 || !hold_ok) begin
        nerr++;
        $display("FAIL rnd%0d_w%0d_timing got=%0d pulses=%0d hold=%0d exp=%0d", i, w, lat, pulses, hold_ok, elat);
      end
      nchk++;
      if (r_res !== e_res || r_exc !== e_exc) begin
        nerr++;
        $display("FAIL rnd%0d_w%0d_%s a=%h b=%h got=%h exc=%b exp=%h exc=%b",
                 i, w, m ? "mul" : "div", a, b, r_res, r_exc, e_res, e_exc);
      end
`ifdef MULTDIV_HI_EN
      nchk++;
      if (r_hi !== e_hi) begin
        nerr++;
        $display("FAIL rnd%0d_w%0d_hi got=%h exp=%h", i, w, r_hi, e_hi);
      end
`endif
    end
  endtask

  // Restart a multiply with a divide at cycle c (8: mid-iteration, 17: the
  // edge that would otherwise have produced RDY).
  task automatic test_restart;
    int cyc[2];
    int lat;
    bit early;
    cyc[0] = 8;
    cyc[1] = 17;
    for (int t = 0; t < 2; t++) begin
      early = 1'b0;
      @(negedge clock);
      drive(32, 1'b1, 1'b0, 32'd3, 32'd4);
      @(negedge clock);
      drive(32, 1'b0, 1'b0, $urandom, $urandom);
      for (int k = 1; k < cyc[t]; k++) begin
        @(negedge clock);
        if (rdy) early = 1'b1;
      end
      drive(32, 1'b0, 1'b1, 32'd20, 32'd5);
      @(negedge clock);
      drive(32, 1'b0, 1'b0, $urandom, $urandom);
      if (rdy) early = 1'b1;
      nchk++;
      if (early) begin
        nerr++;
        $display("FAIL restart%0d_abandoned got rdy=1 exp no rdy", cyc[t]);
      end
      lat = -1;
      for (int k = 1; k <= 36; k++) begin
        @(negedge clock);
        if (rdy && lat < 0) begin
          lat = k;
          nchk++;
          if (res !== 32'd4 || exc !== 1'b0) begin
            nerr++;
            $display("FAIL restart%0d_result got=%h exc=%b exp=00000004 exc=0", cyc[t], res, exc);
          end
        end
      end
      nchk++;
      if (lat !== 33) begin
        nerr++;
        $display("FAIL restart%0d_latency got=%0d exp=33", cyc[t], lat);
      end
    end
  endtask

  task automatic test_reset_abort;
    int lat, pulses;
    bit clr_ok, hold_ok, seen;
    logic [31:0] r_res, r_hi;
    logic r_exc;
    run_op(32, 1'b1, 1'b0, 32'd9, 32'd9, lat, pulses, clr_ok, hold_ok, r_res, r_hi, r_exc);
    nchk++;
    if (r_res !== 32'd81) begin
      nerr++;
      $display("FAIL pre_reset_result got=%h exp=00000051", r_res);
    end
    // Mid-cycle reset while the result is being held: must clear without a clock edge.
    #2 reset = 1'b1;
    #1;
    nchk++;
    if ({res, exc, rdy} !== 34'b0) begin
      nerr++;
      $display("FAIL reset_hold_clear got=%h exp=0", {res, exc, rdy});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    drive(32, 1'b0, 1'b1, 32'd1000, 32'd3);
    @(negedge clock);
    drive(32, 1'b0, 1'b0, $urandom, $urandom);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    nchk++;
    if ({res, exc, rdy} !== 34'b0) begin
      nerr++;
      $display("FAIL reset_mid_div got=%h exp=0", {res, exc, rdy});
    end
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (rdy) seen = 1'b1;
    end
    nchk++;
    if (seen) begin
      nerr++;
      $display("FAIL reset_no_rdy got rdy=1 exp no rdy");
    end
    run_op(32, 1'b1, 1'b0, 32'd2, 32'd2, lat, pulses, clr_ok, hold_ok, r_res, r_hi, r_exc);
    nchk++;
    if (lat !== 17 || r_res !== 32'd4 || r_exc !== 1'b0) begin
      nerr++;
      $display("FAIL post_reset_mul got lat=%0d res=%h exc=%b exp lat=17 res=00000004 exc=0", lat, r_res, r_exc);
    end
  endtask

  task automatic test_width8;
    int lat, pulses;
    bit clr_ok, hold_ok;
    logic [31:0] r_res, r_hi;
    logic r_exc;
    run_op(8, 1'b1, 1'b0, 32'h7F, 32'h02, lat, pulses, clr_ok, hold_ok, r_res, r_hi, r_exc);
    nchk++;
    if (lat !== 5 || pulses !== 1 || r_res !== 32'hFE || r_exc !== 1'b1) begin
      nerr++;
      $display("FAIL w8_mul_7f_2 got lat=%0d pulses=%0d res=%h exc=%b exp lat=5 pulses=1 res=fe exc=1",
               lat, pulses, r_res, r_exc);
    end
    run_op(8, 1'b0, 1'b1, 32'h80, 32'hFF, lat, pulses, clr_ok, hold_ok, r_res, r_hi, r_exc);
    nchk++;
    if (lat !== 9 || r_res !== 32'h80 || r_exc !== 1'b1) begin
      nerr++;
      $display("FAIL w8_div_min_m1 got lat=%0d res=%h exc=%b exp lat=9 res=80 exc=1", lat, r_res, r_exc);
    end
    test_random(8, 16);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random(32, 24);
    test_restart();
    test_reset_abort();
    test_width8();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
